// File: rtl/conv_npu_pkg.sv
// Shared types and width defaults for the conv-window instruction decoder.
// Holds the decoder FSM state encoding and the sideband beat record that travels
// alongside BRAM reads. Width defaults are fixed here and overridable per instance.
package conv_npu_pkg;

  localparam int FRAM_AW_DEF = 16;
  localparam int KRAM_AW_DEF = 16;
  localparam int DW_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } dec_state_e;

  // One issued beat as seen by the MAC array and writeback, RD_LAT cycles later.
  // wb_addr is sized for the widest feature address space; the decoder zero-extends.
  typedef struct packed {
    logic                   valid;
    logic                   first;
    logic                   last;
    logic                   bias;
    logic                   wb;
    logic                   relu;
    logic [FRAM_AW_DEF-1:0] wb_addr;
  } dec_beat_t;

endpackage

// File: rtl/conv_dec_sideband_pipe.sv
// Purpose: delays the per-beat sideband record so it lines up with BRAM read data.
// Latency: DEPTH cycles, fixed. Backpressure: none, shifts every cycle.
// Ports: clk, rst (sync, active-high, clears all stages), din/dout beat records,
//        pending = some stage holds a valid beat.
module conv_dec_sideband_pipe
  import conv_npu_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  dec_beat_t din,
  output dec_beat_t dout,
  output logic      pending
);

  dec_beat_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) pending = pending | stage[i].valid;
  end

endmodule

// File: rtl/conv_decoder.sv
// Purpose: expands one conv-window instruction into FRAM/KRAM reads, MAC beats and writebacks.
// Latency: first read 2 cycles after the accept cycle; mac_*/wb_* trail the reads by RD_LAT.
// Backpressure: decoder_ready only in IDLE; optional mac_stall (CONV_DEC_STALL_EN) freezes issue.
// Ports: clk/rst (sync, active-high); inst_valid/decoder_ready handshake with stride_* fields;
//        fram_ren/fram_raddr, kram_ren/kram_raddr read requests; mac_valid/first/last/bias beat;
//        wb_valid/wb_addr/wb_relu per output channel; busy; mac_stall only with CONV_DEC_STALL_EN.
module conv_decoder
  import conv_npu_pkg::*;
#(
  parameter int FRAM_AW = FRAM_AW_DEF,
  parameter int KRAM_AW = KRAM_AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_valid,
  output logic               decoder_ready,
  input  logic [FRAM_AW-1:0] stride_feature_baseaddr,
  input  logic [KRAM_AW-1:0] stride_kernel_baseaddr,
  input  logic [DW-1:0]      stride_feature_chin,
  input  logic [DW-1:0]      stride_feature_chout,
  input  logic [DW-1:0]      stride_feature_width,
  input  logic [DW-1:0]      stride_feature_height,
  input  logic [7:0]         stride_kernel_sizeh,
  input  logic [7:0]         stride_kernel_sizew,
  input  logic               stride_has_bias,
  input  logic               stride_has_relu,
  input  logic [FRAM_AW-1:0] stride_wb_baseaddr,
  input  logic [DW-1:0]      stride_wb_ch_offset,
  output logic               fram_ren,
  output logic [FRAM_AW-1:0] fram_raddr,
  output logic               kram_ren,
  output logic [KRAM_AW-1:0] kram_raddr,
  output logic               mac_valid,
  output logic               mac_first,
  output logic               mac_last,
  output logic               mac_bias,
  output logic               wb_valid,
  output logic [FRAM_AW-1:0] wb_addr,
  output logic               wb_relu,
  output logic               busy
`ifdef CONV_DEC_STALL_EN
  ,
  input  logic               mac_stall
`endif
);

  dec_state_e state, state_nxt;

  logic [FRAM_AW-1:0] fbase_q, wb_base_q, plane_q, plane;
  logic [KRAM_AW-1:0] kbase_q;
  logic [DW-1:0]      chin_q, chout_q, width_q, sizeh_q, sizew_q, wb_off_q;
  logic               has_bias_q, has_relu_q;

  logic [DW-1:0]      co, ci, kh, kw;
  logic               in_bias;
  logic [FRAM_AW-1:0] ch_ptr, row_ptr, wb_ptr;  // base+ci*plane, ch_ptr+kh*width, wb_base+co*offset
  logic [KRAM_AW-1:0] kram_ptr;
  logic [7:0]         drain_cnt;

  logic stall, beat, zero_dim;
  logic last_kw, last_kh, last_ci, last_elem, co_done, last_co;

`ifdef CONV_DEC_STALL_EN
  assign stall = mac_stall;
`else
  assign stall = 1'b0;
`endif

  // Plane size wraps to the feature address width, like every other address term.
  assign plane = FRAM_AW'(stride_feature_width) * FRAM_AW'(stride_feature_height);

  assign zero_dim  = (chin_q == '0) || (chout_q == '0) || (sizeh_q == '0) || (sizew_q == '0);
  assign last_kw   = (kw == sizew_q - 1'b1);
  assign last_kh   = (kh == sizeh_q - 1'b1);
  assign last_ci   = (ci == chin_q - 1'b1);
  assign last_co   = (co == chout_q - 1'b1);
  assign last_elem = last_kw && last_kh && last_ci;
  // A channel closes on its bias beat, or on its last data beat when there is no bias.
  assign co_done   = in_bias || (last_elem && !has_bias_q);
  assign beat      = (state == ISSUE) && !stall;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inst_valid) state_nxt = LOAD;
      LOAD:    state_nxt = zero_dim ? IDLE : ISSUE;
      ISSUE:   if (beat && co_done && last_co) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 8'(RD_LAT - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fbase_q    <= '0;
      wb_base_q  <= '0;
      plane_q    <= '0;
      kbase_q    <= '0;
      chin_q     <= '0;
      chout_q    <= '0;
      width_q    <= '0;
      sizeh_q    <= '0;
      sizew_q    <= '0;
      wb_off_q   <= '0;
      has_bias_q <= 1'b0;
      has_relu_q <= 1'b0;
      co         <= '0;
      ci         <= '0;
      kh         <= '0;
      kw         <= '0;
      in_bias    <= 1'b0;
      ch_ptr     <= '0;
      row_ptr    <= '0;
      wb_ptr     <= '0;
      kram_ptr   <= '0;
      drain_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && inst_valid) begin
        fbase_q    <= stride_feature_baseaddr;
        kbase_q    <= stride_kernel_baseaddr;
        chin_q     <= stride_feature_chin;
        chout_q    <= stride_feature_chout;
        width_q    <= stride_feature_width;
        plane_q    <= plane;
        sizeh_q    <= DW'(stride_kernel_sizeh);
        sizew_q    <= DW'(stride_kernel_sizew);
        has_bias_q <= stride_has_bias;
        has_relu_q <= stride_has_relu;
        wb_base_q  <= stride_wb_baseaddr;
        wb_off_q   <= stride_wb_ch_offset;
      end

      if (state == LOAD) begin
        co       <= '0;
        ci       <= '0;
        kh       <= '0;
        kw       <= '0;
        in_bias  <= 1'b0;
        ch_ptr   <= fbase_q;
        row_ptr  <= fbase_q;
        kram_ptr <= kbase_q;
        wb_ptr   <= wb_base_q;
      end

      drain_cnt <= (state == DRAIN) ? drain_cnt + 8'd1 : 8'd0;

      // Nested co{ci{kh{kw}}} walk; pointers step by width/plane so no multiplier sits in the loop.
      if (beat) begin
        kram_ptr <= kram_ptr + 1'b1;
        if (in_bias) begin
          in_bias <= 1'b0;
        end else if (!last_kw) begin
          kw <= kw + 1'b1;
        end else begin
          kw <= '0;
          if (!last_kh) begin
            kh      <= kh + 1'b1;
            row_ptr <= row_ptr + FRAM_AW'(width_q);
          end else begin
            kh <= '0;
            if (!last_ci) begin
              ci      <= ci + 1'b1;
              ch_ptr  <= ch_ptr + plane_q;
              row_ptr <= ch_ptr + plane_q;
            end else begin
              ci      <= '0;
              ch_ptr  <= fbase_q;
              row_ptr <= fbase_q;
              in_bias <= has_bias_q;
            end
          end
        end
        if (co_done) begin
          co     <= co + 1'b1;
          wb_ptr <= wb_ptr + FRAM_AW'(wb_off_q);
        end
      end
    end
  end

  assign decoder_ready = (state == IDLE);
  assign kram_ren      = beat;
  assign fram_ren      = beat && !in_bias;
  // Addresses stay visible (and frozen) through stalls, and read as zero outside ISSUE.
  assign fram_raddr    = (state == ISSUE) ? row_ptr + FRAM_AW'(kw) : '0;
  assign kram_raddr    = (state == ISSUE) ? kram_ptr : '0;

  dec_beat_t beat_in, beat_out;
  logic      pipe_pending;

  always_comb begin
    beat_in = '0;
    if (beat) begin
      beat_in.valid = 1'b1;
      beat_in.first = !in_bias && (ci == '0) && (kh == '0) && (kw == '0);
      beat_in.last  = co_done;
      beat_in.bias  = in_bias;
      beat_in.wb    = co_done;
      if (co_done) begin
        beat_in.relu    = has_relu_q;
        beat_in.wb_addr = FRAM_AW_DEF'(wb_ptr);
      end
    end
  end

  conv_dec_sideband_pipe #(.DEPTH(RD_LAT)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .din     (beat_in),
    .dout    (beat_out),
    .pending (pipe_pending)
  );

  assign mac_valid = beat_out.valid;
  assign mac_first = beat_out.first;
  assign mac_last  = beat_out.last;
  assign mac_bias  = beat_out.bias;
  assign wb_valid  = beat_out.wb;
  assign wb_addr   = beat_out.wb_addr[FRAM_AW-1:0];
  assign wb_relu   = beat_out.relu;
  assign busy      = (state != IDLE) || pipe_pending;

endmodule

// File: tb/tb_conv_decoder.sv
`timescale 1ns/1ps
module tb_conv_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        inst_valid = 1'b0;
  logic        decoder_ready;
  logic [15:0] f_base = '0, k_base = '0, chin = '0, chout = '0, width = '0, height = '0;
  logic [7:0]  sizeh = '0, sizew = '0;
  logic        has_bias = 1'b0, has_relu = 1'b0;
  logic [15:0] wb_base = '0, wb_off = '0;
  logic        fram_ren, kram_ren, mac_valid, mac_first, mac_last, mac_bias;
  logic        wb_valid, wb_relu, busy;
  logic [15:0] fram_raddr, kram_raddr, wb_addr;
`ifdef CONV_DEC_STALL_EN
  logic        mac_stall = 1'b0;
`endif

  conv_decoder #(.FRAM_AW(16), .KRAM_AW(16), .DW(16), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .decoder_ready(decoder_ready),
    .stride_feature_baseaddr(f_base), .stride_kernel_baseaddr(k_base),
    .stride_feature_chin(chin), .stride_feature_chout(chout),
    .stride_feature_width(width), .stride_feature_height(height),
    .stride_kernel_sizeh(sizeh), .stride_kernel_sizew(sizew),
    .stride_has_bias(has_bias), .stride_has_relu(has_relu),
    .stride_wb_baseaddr(wb_base), .stride_wb_ch_offset(wb_off),
    .fram_ren(fram_ren), .fram_raddr(fram_raddr), .kram_ren(kram_ren), .kram_raddr(kram_raddr),
    .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last), .mac_bias(mac_bias),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_relu(wb_relu), .busy(busy)
`ifdef CONV_DEC_STALL_EN
    , .mac_stall(mac_stall)
`endif
  );

  typedef struct { logic fren; logic [15:0] faddr; logic [15:0] kaddr; } iss_t;
  typedef struct { logic first; logic last; logic bias; } mac_t;
  typedef struct { logic [15:0] addr; logic relu; } wb_t;

  iss_t iss_q[$];
  mac_t mac_q[$];
  wb_t  wb_q[$];

  int vectors = 0;
  int miscompares = 0;
  int n_accepts = 0;
  int since_acc = -1;
  int acc_beats = 0;
  logic prev_issue = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference expansion of one instruction, written directly from the loop definition.
  task automatic push_inst(output int nbeats);
    int idx = 0;
    logic [15:0] plane = 16'(width * height);
    nbeats = 0;
    if (chin == 0 || chout == 0 || sizeh == 0 || sizew == 0) return;
    for (int co = 0; co < int'(chout); co++) begin
      for (int ci = 0; ci < int'(chin); ci++)
        for (int kh = 0; kh < int'(sizeh); kh++)
          for (int kw = 0; kw < int'(sizew); kw++) begin
            iss_q.push_back('{1'b1, 16'(f_base + ci * plane + kh * width + kw), 16'(k_base + idx)});
            mac_q.push_back('{(ci == 0 && kh == 0 && kw == 0),
                              (!has_bias && ci == chin - 1 && kh == sizeh - 1 && kw == sizew - 1),
                              1'b0});
            idx++;
          end
      if (has_bias) begin
        iss_q.push_back('{1'b0, 16'h0, 16'(k_base + idx)});
        mac_q.push_back('{1'b0, 1'b1, 1'b1});
        idx++;
      end
      wb_q.push_back('{16'(wb_base + co * wb_off), has_relu});
    end
    nbeats = idx;
  endtask

  // Monitor / scoreboard: inputs change at posedge+1, outputs sampled on the falling edge.
  always @(negedge clk) begin
    iss_t e;
    mac_t m;
    wb_t  w;
    int   nb;
    if (rst) begin
      prev_issue = 1'b0;
      since_acc  = -1;
    end else begin
      if (kram_ren) begin
        if (iss_q.size() == 0) check("iss_unexpected", 1, 0);
        else begin
          e = iss_q.pop_front();
          check("fram_ren", fram_ren, e.fren);
          if (e.fren) check("fram_raddr", fram_raddr, e.faddr);
          check("kram_raddr", kram_raddr, e.kaddr);
        end
      end else check("fram_ren_idle", fram_ren, 0);
      check("mac_valid_align", mac_valid, prev_issue);
      check("wb_with_last", wb_valid, mac_valid && mac_last);
      if (mac_valid) begin
        if (mac_q.size() == 0) check("mac_unexpected", 1, 0);
        else begin
          m = mac_q.pop_front();
          check("mac_first", mac_first, m.first);
          check("mac_last", mac_last, m.last);
          check("mac_bias", mac_bias, m.bias);
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          w = wb_q.pop_front();
          check("wb_addr", wb_addr, w.addr);
          check("wb_relu", wb_relu, w.relu);
        end
      end
      check("ready_vs_busy", decoder_ready, !busy);
      if (since_acc >= 0) begin
        since_acc++;
        if (since_acc == 1) begin
          check("load_ready", decoder_ready, 0);
          check("load_ren", kram_ren, 0);
        end else if (since_acc == 2) begin
          check("first_beat_lat", kram_ren, acc_beats > 0);
          check("zero_ready_lat", decoder_ready, acc_beats == 0);
          since_acc = -1;
        end
      end
      prev_issue = kram_ren;
      if (inst_valid && decoder_ready) begin
        push_inst(nb);
        acc_beats = nb;
        since_acc = 0;
        n_accepts++;
      end
    end
  end

  task automatic set_inst(input logic [15:0] fb, kb, ci, co, w, h, input logic [7:0] sh, sw,
                          input logic b, r, input logic [15:0] wbb, wbo);
    f_base = fb; k_base = kb; chin = ci; chout = co; width = w; height = h;
    sizeh = sh; sizew = sw; has_bias = b; has_relu = r; wb_base = wbb; wb_off = wbo;
  endtask

  task automatic wait_accepts(input int target);
    int i;
    for (i = 0; i < 500 && n_accepts < target; i++) @(posedge clk);
    if (n_accepts < target) check("accept_timeout", n_accepts, target);
    #1;
  endtask

  task automatic send();
    int start = n_accepts;
    inst_valid = 1'b1;
    wait_accepts(start + 1);
    inst_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (decoder_ready && !busy && since_acc < 0 && iss_q.size() == 0 &&
          mac_q.size() == 0 && wb_q.size() == 0) break;
    end
    check("iss_drained", iss_q.size(), 0);
    check("mac_drained", mac_q.size(), 0);
    check("wb_drained", wb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [15:0] fa, ka;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", decoder_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fram_ren", fram_ren, 0);
    check("rst_kram_ren", kram_ren, 0);
    check("rst_mac_valid", mac_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    @(posedge clk); #1;

    // Single 1x1 beat.
    set_inst(16'h10, 16'h20, 1, 1, 4, 4, 1, 1, 0, 1, 16'h80, 16'h8);
    send(); wait_idle();

    // Two input channels, 3x3 kernel over a 5x5 plane.
    set_inst(16'h0, 16'h0, 2, 1, 5, 5, 3, 3, 0, 0, 16'h0, 16'h0);
    send(); wait_idle();

    // Bias beats closing each output channel.
    set_inst(16'h0, 16'h0, 1, 2, 4, 4, 1, 1, 1, 0, 16'h40, 16'd16);
    send(); wait_idle();

    // Non-square kernel, address wrap near the top of the space.
    set_inst(16'hFFF0, 16'hFFFE, 2, 2, 7, 3, 2, 3, 1, 1, 16'hFFF8, 16'h10);
    send(); wait_idle();

    // inst_valid held high across two instructions; fields change once the first is taken.
    set_inst(16'h100, 16'h10, 1, 1, 4, 4, 2, 2, 0, 0, 16'h200, 16'h4);
    start = n_accepts;
    inst_valid = 1'b1;
    wait_accepts(start + 1);
    set_inst(16'h300, 16'h30, 1, 2, 4, 4, 1, 2, 0, 1, 16'h400, 16'h20);
    wait_accepts(start + 2);
    inst_valid = 1'b0;
    wait_idle();

    // Zero output channels: no beats, ready back two cycles after the accept cycle.
    set_inst(16'h10, 16'h10, 1, 0, 4, 4, 1, 1, 0, 0, 16'h0, 16'h0);
    send(); wait_idle();

    // Reset in the middle of ISSUE abandons the instruction.
    set_inst(16'h0, 16'h0, 2, 1, 5, 5, 3, 3, 0, 0, 16'h60, 16'h0);
    send();
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    iss_q.delete(); mac_q.delete(); wb_q.delete();
    @(negedge clk);
    check("midrst_fram_ren", fram_ren, 0);
    check("midrst_kram_ren", kram_ren, 0);
    check("midrst_fram_raddr", fram_raddr, 0);
    check("midrst_mac_valid", mac_valid, 0);
    check("midrst_wb_valid", wb_valid, 0);
    check("midrst_ready", decoder_ready, 1);
    @(posedge clk); #1;
    set_inst(16'h8, 16'h4, 1, 2, 4, 4, 1, 1, 0, 0, 16'h70, 16'h5);
    send(); wait_idle();

`ifdef CONV_DEC_STALL_EN
    // Three stall cycles mid-stream: ren low, addresses frozen, bubbles downstream.
    set_inst(16'h0, 16'h0, 1, 1, 5, 5, 3, 3, 0, 0, 16'h0, 16'h0);
    send();
    repeat (4) @(posedge clk);
    #1 mac_stall = 1'b1;
    @(negedge clk);
    fa = fram_raddr;
    ka = kram_raddr;
    check("stall_kram_ren", kram_ren, 0);
    check("stall_fram_ren", fram_ren, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_kram_ren", kram_ren, 0);
      check("stall_fram_hold", fram_raddr, fa);
      check("stall_kram_hold", kram_raddr, ka);
    end
    @(posedge clk);
    #1 mac_stall = 1'b0;
    wait_idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
